// File: rtl/axis_upsize_hdr_tuser.sv
// axis_upsize_hdr_tuser: packs IN_W-bit AXI-Stream words into IN_W*RATIO-bit beats, LSB lane first.
// Define AXIS_UPSZ_TUSER_HDR_EN to strip each packet's first word into M_AXIS_TUSER.
module axis_upsize_hdr_tuser #(
  parameter int IN_W  = 32,
  parameter int RATIO = 2,
  parameter int CNT_W = 16
) (
  input  logic                    AXIS_ACLK,
  input  logic                    AXIS_ARESET,
  input  logic [IN_W-1:0]         S_AXIS_TDATA,
  input  logic                    S_AXIS_TVALID,
  input  logic                    S_AXIS_TLAST,
  output logic                    S_AXIS_TREADY,
  output logic [IN_W*RATIO-1:0]   M_AXIS_TDATA,
  output logic [IN_W*RATIO/8-1:0] M_AXIS_TSTRB,
  output logic [IN_W-1:0]         M_AXIS_TUSER,
  output logic                    M_AXIS_TVALID,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY,
  output logic [CNT_W-1:0]        PKT_COUNT
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int STB_W = OUT_W / 8;
  localparam int LB    = IN_W / 8;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_acc, r_tdata, w_beat_data;
  logic [STB_W-1:0] r_tstrb, w_beat_strb;
  logic             r_tvalid, r_tlast;
  logic [CNT_W-1:0] r_cnt;
  logic             w_in_xfer, w_m_xfer, w_hdr, w_emit;
  assign S_AXIS_TREADY = !AXIS_ARESET & (!r_tvalid | M_AXIS_TREADY);
  assign w_in_xfer     = S_AXIS_TVALID & S_AXIS_TREADY;
  assign w_m_xfer      = r_tvalid & M_AXIS_TREADY;
  assign w_emit        = w_in_xfer & (S_AXIS_TLAST | (!w_hdr & (r_idx == LAST_IDX)));
  // Accumulator lanes above r_idx are always zero, so the beat is the accumulator plus the incoming lane.
  always_comb begin
    w_beat_data = r_acc;
    w_beat_strb = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_beat_data[k*IN_W +: IN_W] = (k == int'(r_idx)) ? S_AXIS_TDATA : r_acc[k*IN_W +: IN_W];
      w_beat_strb[k*LB +: LB]     = (k <= int'(r_idx)) ? {LB{1'b1}} : {LB{1'b0}};
    end
  end
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_idx    <= '0;
      r_acc    <= '0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_m_xfer) r_tvalid <= 1'b0;
      if (w_m_xfer & r_tlast) r_cnt <= r_cnt + 1'b1;
      if (w_emit) begin
        r_tvalid <= 1'b1;
        r_tlast  <= S_AXIS_TLAST;
        r_tdata  <= w_hdr ? '0 : w_beat_data;
        r_tstrb  <= w_hdr ? '0 : w_beat_strb;
      end
      if (w_in_xfer & !w_hdr) begin
        r_idx <= w_emit ? '0 : r_idx + 1'b1;
        r_acc <= w_emit ? '0 : w_beat_data;
      end
    end
  end
`ifdef AXIS_UPSZ_TUSER_HDR_EN
  typedef enum logic {S_HDR, S_PACK} state_t;
  state_t          r_state, w_state_nxt;
  logic [IN_W-1:0] r_user;
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) r_state <= S_HDR;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_xfer) w_state_nxt = S_AXIS_TLAST ? S_HDR : S_PACK;
  end
  // Header accept needs a free output slot, so TUSER never changes under a stalled beat.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) r_user <= '0;
    else if (w_in_xfer & w_hdr) r_user <= S_AXIS_TDATA;
  end
  assign w_hdr        = (r_state == S_HDR);
  assign M_AXIS_TUSER = r_user;
`else
  assign w_hdr        = 1'b0;
  assign M_AXIS_TUSER = '0;
`endif
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TSTRB  = r_tstrb;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;
  assign PKT_COUNT     = r_cnt;
endmodule

// File: tb/tb_axis_upsize_hdr_tuser.sv
// tb_axis_upsize_hdr_tuser: scoreboard bench, RATIO=2, CNT_W=2; follows AXIS_UPSZ_TUSER_HDR_EN like the DUT.
module tb_axis_upsize_hdr_tuser;
  localparam int IN_W  = 32;
  localparam int RATIO = 2;
  localparam int CNT_W = 2;
  localparam int OUT_W = IN_W * RATIO;
  localparam int STB_W = OUT_W / 8;
`ifdef AXIS_UPSZ_TUSER_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [STB_W-1:0] s;
    logic             l;
    logic [IN_W-1:0]  u;
  } exp_t;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_W-1:0]  s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tlast = 1'b0;
  logic             s_tready;
  logic [OUT_W-1:0] m_tdata;
  logic [STB_W-1:0] m_tstrb;
  logic [IN_W-1:0]  m_tuser;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready = 1'b0;
  logic [CNT_W-1:0] pkt_count;
  exp_t             sb[$];
  int               n_chk = 0;
  int               n_fail = 0;
  int               exp_cnt = 0;
  bit               stall = 1'b0;
  bit               done = 1'b0;
  axis_upsize_hdr_tuser #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
    .AXIS_ACLK(clk),
    .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata),
    .M_AXIS_TSTRB(m_tstrb),
    .M_AXIS_TUSER(m_tuser),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TREADY(m_tready),
    .PKT_COUNT(pkt_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    m_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  always @(negedge clk) begin
    if (rst) exp_cnt = 0;
    else if (m_tvalid && m_tready) begin
      if (sb.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("tdata", m_tdata, e.d);
        check("tstrb", 64'(m_tstrb), 64'(e.s));
        check("tlast", 64'(m_tlast), 64'(e.l));
        check("tuser", 64'(m_tuser), 64'(e.u));
      end
      check("pkt_count", 64'(pkt_count), 64'(exp_cnt));
      if (m_tlast) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    end
  end
  task automatic drive_word(input logic [IN_W-1:0] d, input logic l);
    int t = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      t++;
      if (t > 200) begin
        check("in_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send_pkt(input int n);
    logic [IN_W-1:0] w[$];
    logic [IN_W-1:0] hdr;
    exp_t            e;
    int              first;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    first = HDR_EN ? 1 : 0;
    hdr   = HDR_EN ? w[0] : '0;
    if (HDR_EN && n == 1) begin
      e = '{d: '0, s: '0, l: 1'b1, u: hdr};
      sb.push_back(e);
    end
    for (int i = first; i < n; i += RATIO) begin
      e = '{d: '0, s: '0, l: (i + RATIO >= n), u: hdr};
      for (int k = 0; k < RATIO && i + k < n; k++) begin
        e.d[k*IN_W +: IN_W] = w[i+k];
        e.s[k*(IN_W/8) +: IN_W/8] = '1;
      end
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) drive_word(w[i], i == n - 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask
  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || m_tvalid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_tdata"}, m_tdata, 64'd0);
    check({tag, "_tstrb"}, 64'(m_tstrb), 64'd0);
    check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    check({tag, "_tuser"}, 64'(m_tuser), 64'd0);
    check({tag, "_count"}, 64'(pkt_count), 64'd0);
    check({tag, "_sready"}, 64'(s_tready), 64'd0);
  endtask
  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    send_pkt(4);
    send_pkt(1);
    send_pkt(1);
    send_pkt(3);
    send_pkt(2);
    send_pkt(5);
    for (int i = 0; i < 6; i++) send_pkt($urandom_range(1, 6));
    wait_drain();
    // Hold the sink off while a full beat sits in the output register.
    stall    = 1'b1;
    m_tready = 1'b0;
    done     = 1'b0;
    fork
      begin
        send_pkt(4);
        done = 1'b1;
      end
    join_none
    t = 0;
    while (!m_tvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stall_fill", 64'(m_tvalid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_sready", 64'(s_tready), 64'd0);
      check("stall_mvalid", 64'(m_tvalid), 64'd1);
    end
    stall = 1'b0;
    t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("stall_done", 64'(done), 64'd1);
    wait_drain();
    @(posedge clk);
    #1;
    if (HDR_EN) drive_word($urandom, 1'b0);
    drive_word($urandom, 1'b0);
    rst      = 1'b1;
    s_tvalid = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_pkt(3);
    send_pkt(1);
    send_pkt(2);
    wait_drain();
    @(negedge clk);
    check("final_count", 64'(pkt_count), 64'(exp_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
